sync_memory_ctrl: RTL and testbench

Parametrised single-port synchronous memory with a request/valid handshake and a built-in clear sequencer, the next generation of the fixed 16x256 program/data memory. After reset, or on request, it walks every location and writes a programmable init value. It then serves one read or write per clock with a registered, one-cycle read latency. It sits between the CPU fetch/load-store unit and the memory array.

---
 rtl/sync_memory_ctrl.sv | 89 ++++++++
 tb/tb_sync_memory_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_memory_ctrl.sv
// Single-port synchronous memory with request/valid handshake and a clear
// sequencer that writes INIT_VALUE to every location after reset or on Clear.
module sync_memory_ctrl #(
   parameter int                    Data_WIDTH    = 16,
   parameter int                    Address_WIDTH = 8,
   parameter logic [Data_WIDTH-1:0] INIT_VALUE    = '0
) (
   input  logic                     Clk,
   input  logic                     Reset_N,
   input  logic                     Req,
   input  logic                     Write_EN,
   input  logic [Address_WIDTH-1:0] Address,
   input  logic [Data_WIDTH-1:0]    DIn,
   input  logic                     Clear,
   output logic                     Ready,
   output logic                     Busy,
   output logic [Data_WIDTH-1:0]    DOut,
   output logic                     Valid
);

   localparam int DEPTH = 2 ** Address_WIDTH;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t                   state_q;
   logic [Address_WIDTH-1:0] cnt_q;
   logic [Address_WIDTH-1:0] cnt_d;
   logic [Data_WIDTH-1:0]    dout_q;
   logic                     valid_q;
   logic [Data_WIDTH-1:0]    mem_q [DEPTH];

   logic                     rd_acc;
   logic                     wr_acc;
   logic                     mem_we;
   logic [Address_WIDTH-1:0] mem_addr;
   logic [Data_WIDTH-1:0]    mem_wdata;

   // Clear wins over a simultaneous request, which is dropped rather than queued.
   always_comb begin
      rd_acc    = (state_q == ST_IDLE) && !Clear && Req && Write_EN;
      wr_acc    = (state_q == ST_IDLE) && !Clear && Req && !Write_EN;
      mem_we    = (state_q == ST_CLEAR) || wr_acc;
      mem_addr  = (state_q == ST_CLEAR) ? cnt_q : Address;
      mem_wdata = (state_q == ST_CLEAR) ? INIT_VALUE : DIn;
      cnt_d     = cnt_q + Address_WIDTH'(1);
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               valid_q <= 1'b0;
               cnt_q   <= cnt_d;
               if (cnt_q == '1) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               valid_q <= rd_acc;
               if (rd_acc) begin
                  dout_q <= mem_q[Address];
               end
               if (Clear) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
               end
            end
         endcase
      end
   end

   // The array has no reset; the clear sequence is what initialises it.
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end

   assign Ready = (state_q == ST_IDLE);
   assign Busy  = (state_q == ST_CLEAR);
   assign DOut  = dout_q;
   assign Valid = valid_q;

endmodule

// File: tb/tb_sync_memory_ctrl.sv
// Bench for sync_memory_ctrl: default instance checked every cycle against a
// behavioural model, plus a 32x16 instance exercised with directed vectors.
module tb_sync_memory_ctrl;

   localparam int          DEPTH0 = 256;
   localparam logic [15:0] INIT0  = 16'h0000;
   localparam logic [31:0] INIT1  = 32'hA5A5A5A5;

   logic        Clk;
   logic        rst0_n = 1'b1;
   logic        req0, we0, clr0;
   logic [7:0]  addr0;
   logic [15:0] din0;
   logic        rdy0, busy0, vld0;
   logic [15:0] dout0;

   logic        rst1_n = 1'b1;
   logic        req1, we1, clr1;
   logic [3:0]  addr1;
   logic [31:0] din1;
   logic        rdy1, busy1, vld1;
   logic [31:0] dout1;

   int vec  = 0;
   int miss = 0;
   bit chk_on = 1'b0;

   sync_memory_ctrl dut0 (
      .Clk(Clk), .Reset_N(rst0_n), .Req(req0), .Write_EN(we0), .Address(addr0),
      .DIn(din0), .Clear(clr0), .Ready(rdy0), .Busy(busy0), .DOut(dout0), .Valid(vld0)
   );

   sync_memory_ctrl #(.Data_WIDTH(32), .Address_WIDTH(4), .INIT_VALUE(INIT1)) dut1 (
      .Clk(Clk), .Reset_N(rst1_n), .Req(req1), .Write_EN(we1), .Address(addr1),
      .DIn(din1), .Clear(clr1), .Ready(rdy1), .Busy(busy1), .DOut(dout1), .Valid(vld1)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a clear makes every word INIT at once and blocks service for DEPTH edges.
   int          m_blk;
   logic        m_valid;
   logic [15:0] m_dout;
   logic [15:0] m_mem [DEPTH0];

   always @(posedge Clk or negedge rst0_n) begin
      if (!rst0_n) begin
         m_blk   <= DEPTH0;
         m_valid <= 1'b0;
         m_dout  <= '0;
         for (int i = 0; i < DEPTH0; i++) m_mem[i] <= INIT0;
      end else if (m_blk > 0) begin
         m_blk   <= m_blk - 1;
         m_valid <= 1'b0;
      end else if (clr0) begin
         m_blk   <= DEPTH0;
         m_valid <= 1'b0;
         for (int i = 0; i < DEPTH0; i++) m_mem[i] <= INIT0;
      end else if (req0 && !we0) begin
         m_mem[addr0] <= din0;
         m_valid      <= 1'b0;
      end else if (req0) begin
         m_dout  <= m_mem[addr0];
         m_valid <= 1'b1;
      end else begin
         m_valid <= 1'b0;
      end
   end

   always @(negedge Clk) begin
      if (chk_on) begin
         check("ready0", {31'b0, rdy0}, {31'b0, m_blk == 0});
         check("busy0", {31'b0, busy0}, {31'b0, m_blk != 0});
         check("valid0", {31'b0, vld0}, {31'b0, m_valid});
         check("dout0", {16'b0, dout0}, {16'b0, m_dout});
      end
   end

   task automatic cyc0(input logic r, input logic w, input logic [7:0] a,
                       input logic [15:0] d, input logic c);
      @(negedge Clk);
      #1;
      req0 = r; we0 = w; addr0 = a; din0 = d; clr0 = c;
   endtask

   task automatic cyc1(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
      @(negedge Clk);
      #1;
      req1 = r; we1 = w; addr1 = a; din1 = d;
   endtask

   task automatic wait_ready0(output int n);
      n = 0;
      do begin
         @(posedge Clk);
         #1;
         n++;
      end while (!rdy0 && n < 2000);
   endtask

   task automatic wait_ready1(output int n);
      n = 0;
      do begin
         @(posedge Clk);
         #1;
         n++;
      end while (!rdy1 && n < 2000);
   endtask

   logic [15:0] pat [4];
   int n;

   initial begin
      pat[0] = 16'h9202; pat[1] = 16'h9304; pat[2] = 16'h2621; pat[3] = 16'h1000;
      req0 = 0; we0 = 1; addr0 = '0; din0 = '0; clr0 = 0;
      req1 = 0; we1 = 1; addr1 = '0; din1 = '0; clr1 = 0;

      #1 rst0_n = 1'b0; rst1_n = 1'b0; chk_on = 1'b1;
      #1;
      check("rst_ready", {31'b0, rdy0}, 32'd0);
      check("rst_busy", {31'b0, busy0}, 32'd1);
      check("rst_valid", {31'b0, vld0}, 32'd0);
      check("rst_dout", {16'b0, dout0}, 32'd0);
      check("rst1_ready", {31'b0, rdy1}, 32'd0);

      @(negedge Clk); #1 rst0_n = 1'b1;
      wait_ready0(n);
      check("clear_edges_reset", n, 32'd256);

      foreach (pat[k]) begin
         logic [7:0] a;
         a = (k == 0) ? 8'h00 : (k == 1) ? 8'h7F : 8'hFF;
         if (k < 3) begin
            cyc0(1, 1, a, 0, 0);
            cyc0(0, 1, 0, 0, 0);
            check("init_read_valid", {31'b0, vld0}, 32'd1);
            check("init_read_data", {16'b0, dout0}, 32'h0000);
         end
      end

      // Write followed immediately by a read of the same address.
      cyc0(1, 0, 8'h0A, 16'h0666, 0);
      cyc0(1, 1, 8'h0A, 0, 0);
      cyc0(0, 1, 0, 0, 0);
      check("wr_rd_valid", {31'b0, vld0}, 32'd1);
      check("wr_rd_data", {16'b0, dout0}, 32'h0666);

      for (int i = 0; i < 4; i++) cyc0(1, 0, 8'(i), pat[i], 0);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) cyc0(1, 1, 8'(i), 0, 0);
         else       cyc0(0, 1, 0, 0, 0);
         if (i > 0) begin
            check("pipe_valid", {31'b0, vld0}, 32'd1);
            check("pipe_data", {16'b0, dout0}, {16'b0, pat[i-1]});
         end
      end

      // Clear arriving together with a write request: the write must be lost.
      cyc0(1, 0, 8'h10, 16'hBEEF, 0);
      cyc0(1, 1, 8'h10, 0, 0);
      cyc0(1, 0, 8'h20, 16'h1234, 1);
      check("pre_clear_data", {16'b0, dout0}, 32'hBEEF);
      @(posedge Clk); #1;
      check("clear_busy", {31'b0, busy0}, 32'd1);
      cyc0(0, 1, 0, 0, 0);
      wait_ready0(n);
      check("clear_edges_pulse", n, 32'd256);
      cyc0(1, 1, 8'h10, 0, 0);
      cyc0(1, 1, 8'h20, 0, 0);
      check("cleared_10", {16'b0, dout0}, {16'b0, INIT0});
      cyc0(0, 1, 0, 0, 0);
      check("dropped_20", {16'b0, dout0}, {16'b0, INIT0});

      // Reset while a read result is being presented.
      cyc0(1, 0, 8'h11, 16'h5555, 0);
      cyc0(1, 1, 8'h11, 0, 0);
      cyc0(0, 1, 0, 0, 0);
      check("pre_rst_valid", {31'b0, vld0}, 32'd1);
      rst0_n = 1'b0;
      #1;
      check("rst_rd_valid", {31'b0, vld0}, 32'd0);
      check("rst_rd_dout", {16'b0, dout0}, 32'd0);
      @(negedge Clk); #1 rst0_n = 1'b1;
      wait_ready0(n);
      check("clear_edges_rst_rd", n, 32'd256);

      // Reset when the clear counter has reached 100.
      cyc0(1, 0, 8'h11, 16'h5555, 0);
      cyc0(1, 1, 8'h11, 0, 0);
      cyc0(0, 1, 0, 0, 1);
      @(posedge Clk); #1;
      cyc0(0, 1, 0, 0, 0);
      repeat (100) @(posedge Clk);
      #1;
      check("mid_clear_dout_held", {16'b0, dout0}, 32'h5555);
      rst0_n = 1'b0;
      #1;
      check("rst_mid_dout", {16'b0, dout0}, 32'd0);
      check("rst_mid_valid", {31'b0, vld0}, 32'd0);
      check("rst_mid_ready", {31'b0, rdy0}, 32'd0);
      @(negedge Clk); #1 rst0_n = 1'b1;
      wait_ready0(n);
      check("clear_edges_rst_mid", n, 32'd256);
      cyc0(1, 1, 8'h11, 0, 0);
      cyc0(0, 1, 0, 0, 0);
      check("after_rst_11", {16'b0, dout0}, {16'b0, INIT0});

      // Second instance: 32-bit data, 16 locations, non-zero init word.
      @(negedge Clk); #1 rst1_n = 1'b1;
      wait_ready1(n);
      check("p_clear_edges", n, 32'd16);
      for (int i = 0; i < 16; i++) begin
         cyc1(1, 1, 4'(i), 0);
         cyc1(0, 1, 0, 0);
         check("p_init_valid", {31'b0, vld1}, 32'd1);
         check("p_init_data", dout1, 32'hA5A5A5A5);
      end
      cyc1(1, 0, 4'hF, 32'hFFFFFFFF);
      cyc1(1, 1, 4'hF, 0);
      cyc1(0, 1, 0, 0);
      check("p_wr_rd_valid", {31'b0, vld1}, 32'd1);
      check("p_wr_rd_data", dout1, 32'hFFFFFFFF);
      check("p_ready", {31'b0, rdy1}, 32'd1);

      @(negedge Clk);
      #1 chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
